// File: rtl/aha_cg_pkg.sv
// Shared types and helpers for the clock-gate idle controller.
package aha_cg_pkg;

   // Controller states; 3-bit encoding leaves room for future states.
   typedef enum logic [2:0] {
      ST_RUN   = 3'd0,
      ST_COUNT = 3'd1,
      ST_REQ   = 3'd2,
      ST_GATED = 3'd3,
      ST_WAKE  = 3'd4
   } cg_state_t;

   // Default settling period after the clock is restored.
   localparam int WAKE_CYCLES_DEF = 2;

   // Output bundle, decoded purely from state so outputs can be registered.
   typedef struct packed {
      logic cg_en;
      logic stop_req;
      logic clk_ready;
      logic gated;
   } cg_out_t;

   function automatic cg_out_t cg_decode(cg_state_t s);
      cg_out_t o;
      o = '{cg_en: 1'b1, stop_req: 1'b0, clk_ready: 1'b1, gated: 1'b0};
      case (s)
         ST_REQ:   o.stop_req = 1'b1;
         ST_GATED: o = '{cg_en: 1'b0, stop_req: 1'b1, clk_ready: 1'b0, gated: 1'b1};
         ST_WAKE:  o = '{cg_en: 1'b1, stop_req: 1'b1, clk_ready: 1'b0, gated: 1'b0};
         default:  ;
      endcase
      return o;
   endfunction

   function automatic int max_int(int a, int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/aha_clock_gate_ctrl_if.sv
// Handshake between the gate controller and the gateable domain / ICG.
interface aha_clock_gate_ctrl_if;
   logic BUSY;
   logic WAKE_REQ;
   logic STOP_ACK;
   logic STOP_REQ;
   logic CG_EN;
   logic CLK_READY;
   logic GATED;

   // Controller side.
   modport master (
      input  BUSY, WAKE_REQ, STOP_ACK,
      output STOP_REQ, CG_EN, CLK_READY, GATED
   );

   // Domain side.
   modport slave (
      output BUSY, WAKE_REQ, STOP_ACK,
      input  STOP_REQ, CG_EN, CLK_READY, GATED
   );
endinterface

// File: rtl/aha_sat_counter.sv
// Saturating up-counter with synchronous clear.
module aha_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   // Clear wins; otherwise count up and stick at all-ones.
   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (inc && (cnt != {W{1'b1}}))
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/aha_clock_gate_ctrl.sv
// Idle-detect controller driving the ICG enable for one gateable domain.
// Runs on the always-on clock; all outputs registered from next state.
module aha_clock_gate_ctrl
   import aha_cg_pkg::*;
#(
   parameter int CNT_W       = 8,
   parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
   parameter int EVT_W       = 16
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  ENABLE,
   input  logic [CNT_W-1:0]      IDLE_CYCLES,
   aha_clock_gate_ctrl_if.master dom,
   output logic [EVT_W-1:0]      GATE_EVENTS
);

   // Shared idle/wake counter must hold both the idle limit and WAKE_CYCLES-1.
   localparam int CW = max_int(CNT_W, $clog2(WAKE_CYCLES) + 1);
   localparam logic [CW-1:0] WAKE_LAST = CW'(WAKE_CYCLES - 1);

   cg_state_t        state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [CNT_W-1:0] limit, limit_n;
   cg_out_t          outs_q;
   logic             wake;
   logic             gate_inc;

   assign wake = dom.BUSY | dom.WAKE_REQ | ~ENABLE;

   // Next-state, counter and limit update; abort always has priority.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      limit_n  = limit;
      gate_inc = 1'b0;
      case (state)
         ST_RUN: begin
            if (!wake) begin
               state_n = ST_COUNT;
               cnt_n   = '0;
               limit_n = IDLE_CYCLES;
            end
         end
         ST_COUNT: begin
            if (wake)
               state_n = ST_RUN;
            else if (cnt == CW'(limit))
               state_n = ST_REQ;
            else
               cnt_n = cnt + 1'b1;
         end
         ST_REQ: begin
            // No timeout: the domain may take as long as it needs to ack.
            if (wake)
               state_n = ST_RUN;
            else if (dom.STOP_ACK) begin
               state_n  = ST_GATED;
               gate_inc = 1'b1;
            end
         end
         ST_GATED: begin
            if (wake) begin
               state_n = ST_WAKE;
               cnt_n   = '0;
            end
         end
         ST_WAKE: begin
            // Settling always runs to completion regardless of activity.
            if (cnt == WAKE_LAST)
               state_n = ST_RUN;
            else
               cnt_n = cnt + 1'b1;
         end
         default: state_n = ST_RUN;
      endcase
   end

   // State register with outputs decoded from the next state.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state  <= ST_RUN;
         cnt    <= '0;
         limit  <= '0;
         outs_q <= cg_decode(ST_RUN);
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         limit  <= limit_n;
         outs_q <= cg_decode(state_n);
      end
   end

   assign dom.CG_EN     = outs_q.cg_en;
   assign dom.STOP_REQ  = outs_q.stop_req;
   assign dom.CLK_READY = outs_q.clk_ready;
   assign dom.GATED     = outs_q.gated;

   aha_sat_counter #(.W(EVT_W)) u_evt_cnt (
      .clk (CLK),
      .clr (RESET),
      .inc (gate_inc),
      .cnt (GATE_EVENTS)
   );

endmodule

// File: tb/tb_aha_clock_gate_ctrl.sv
// Directed bench for the clock-gate controller with an expectation queue.
module tb_aha_clock_gate_ctrl;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       ENABLE;
   logic [7:0] IDLE_CYCLES;
   logic [1:0] GATE_EVENTS;

   aha_clock_gate_ctrl_if cg_if ();

   aha_clock_gate_ctrl #(.CNT_W(8), .WAKE_CYCLES(2), .EVT_W(2)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .ENABLE      (ENABLE),
      .IDLE_CYCLES (IDLE_CYCLES),
      .dom         (cg_if),
      .GATE_EVENTS (GATE_EVENTS)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [5:0] val;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // {CG_EN, STOP_REQ, CLK_READY, GATED, GATE_EVENTS}
   wire [5:0] obs = {cg_if.CG_EN, cg_if.STOP_REQ, cg_if.CLK_READY, cg_if.GATED, GATE_EVENTS};

   function automatic logic [5:0] mk(bit cg, bit sr, bit rdy, bit g, int ev);
      logic [1:0] e;
      e = ev[1:0];
      return {cg, sr, rdy, g, e};
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty: observed=%b expected=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", e.tag, obs, e.val);
         end
      end
      checks++;
      assert (!(obs[5] === 1'b0 && obs[4] === 1'b0)) else begin
         errors++;
         $error("FAIL inv_stopreq: observed=%b expected=STOP_REQ=1 while CG_EN=0", obs);
      end
      checks++;
      assert (!(obs[3] === 1'b1 && obs[5] !== 1'b1)) else begin
         errors++;
         $error("FAIL inv_ready: observed=%b expected=CG_EN=1 while CLK_READY=1", obs);
      end
   endtask

   // Expectation is queued as the stimulus is applied, checked after the edge.
   task automatic step(string tag, logic [5:0] v);
      sb.push_back('{tag, v});
      tick();
      check();
   endtask

   initial begin
      int prev;
      int ev;
      RESET          = 1'b1;
      ENABLE         = 1'b1;
      IDLE_CYCLES    = 8'd3;
      cg_if.BUSY     = 1'b1;
      cg_if.WAKE_REQ = 1'b0;
      cg_if.STOP_ACK = 1'b0;
      step("reset", mk(1, 0, 1, 0, 0));
      step("reset", mk(1, 0, 1, 0, 0));

      // Idle to gated with IDLE_CYCLES=3: CG_EN falls 6 edges after release.
      RESET = 1'b0; cg_if.BUSY = 1'b0; cg_if.STOP_ACK = 1'b1;
      for (int i = 0; i < 4; i++) step("count", mk(1, 0, 1, 0, 0));
      step("req", mk(1, 1, 1, 0, 0));
      step("gated", mk(0, 1, 0, 1, 1));
      step("gated_hold", mk(0, 1, 0, 1, 1));
      step("gated_hold", mk(0, 1, 0, 1, 1));

      // WAKE_REQ pulse; BUSY toggling during settling is ignored.
      cg_if.WAKE_REQ = 1'b1;
      step("wake1", mk(1, 1, 0, 0, 1));
      cg_if.WAKE_REQ = 1'b0; cg_if.BUSY = 1'b1;
      step("wake2", mk(1, 1, 0, 0, 1));
      cg_if.BUSY = 1'b0; cg_if.STOP_ACK = 1'b0;
      step("wake_run", mk(1, 0, 1, 0, 1));

      // Limit 0; REQ waits indefinitely; abort wins over simultaneous ack.
      IDLE_CYCLES = 8'd0;
      step("abort_count", mk(1, 0, 1, 0, 1));
      step("abort_req", mk(1, 1, 1, 0, 1));
      for (int i = 0; i < 3; i++) step("req_wait", mk(1, 1, 1, 0, 1));
      cg_if.BUSY = 1'b1; cg_if.STOP_ACK = 1'b1;
      step("abort", mk(1, 0, 1, 0, 1));
      step("abort_run", mk(1, 0, 1, 0, 1));

      // Reset while gated.
      cg_if.BUSY = 1'b0;
      step("rg_count", mk(1, 0, 1, 0, 1));
      step("rg_req", mk(1, 1, 1, 0, 1));
      step("rg_gated", mk(0, 1, 0, 1, 2));
      RESET = 1'b1; cg_if.BUSY = 1'b1;
      step("reset_gated", mk(1, 0, 1, 0, 0));
      RESET = 1'b0;

      // ENABLE low forces the clock on.
      ENABLE = 1'b0; cg_if.BUSY = 1'b0; cg_if.STOP_ACK = 1'b1;
      for (int i = 0; i < 8; i++) step("enable_low", mk(1, 0, 1, 0, 0));

      // Five gate/wake rounds; 2-bit event counter saturates at 3.
      ENABLE = 1'b1;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         ev = (i + 1 > 3) ? 3 : i + 1;
         step("sat_count", mk(1, 0, 1, 0, prev));
         step("sat_req", mk(1, 1, 1, 0, prev));
         step("sat_gated", mk(0, 1, 0, 1, ev));
         cg_if.WAKE_REQ = 1'b1;
         step("sat_wake1", mk(1, 1, 0, 0, ev));
         cg_if.WAKE_REQ = 1'b0;
         step("sat_wake2", mk(1, 1, 0, 0, ev));
         step("sat_run", mk(1, 0, 1, 0, ev));
         prev = ev;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
